// File: rtl/fsm_seq_ctrl.sv
// Data-pattern sequencing controller: IDLE -> ON -> OFF -> WAIT -> IDLE with
// masked pattern matching, programmable WAIT dwell, ON timeout and trip counting.
module fsm_seq_ctrl #(
  parameter int DW = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] data,
  input  logic          en,
  input  logic          abort,
  input  logic [DW-1:0] cfg_idle_pat,
  input  logic [DW-1:0] cfg_off_pat,
  input  logic [DW-1:0] cfg_mask,
  input  logic [CW-1:0] cfg_wait_len,
  input  logic [CW-1:0] cfg_timeout,
  output logic [2:0]    state,
  output logic          busy,
  output logic          done_pulse,
  output logic          timeout_pulse,
  output logic [CW-1:0] trip_cnt
);

  typedef enum logic [2:0] {
    S_IDLE = 3'b000,
    S_ON   = 3'b001,
    S_OFF  = 3'b010,
    S_WAIT = 3'b100
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] dwell_q, dwell_d;
  logic [CW-1:0] trip_q, trip_d;
  logic          done_q, done_d;
  logic          tmo_q, tmo_d;
  logic          busy_q;
  logic          idle_hit_s, off_hit_s;
  logic [CW-1:0] tmo_lim_s;

  assign idle_hit_s = (((data ^ cfg_idle_pat) & cfg_mask) == {DW{1'b0}});
  assign off_hit_s  = (((data ^ cfg_off_pat) & cfg_mask) == {DW{1'b0}});
  assign tmo_lim_s  = cfg_timeout - CW'(1);

  // Next-state, dwell, pulse and trip-count logic
  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    trip_d  = trip_q;
    done_d  = 1'b0;
    tmo_d   = 1'b0;

    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (en && !idle_hit_s) begin
            state_d = S_ON;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_ON: begin
          // A pattern hit wins over a timeout expiring in the same cycle.
          if (off_hit_s) begin
            state_d = S_OFF;
          end else if ((cfg_timeout != {CW{1'b0}}) && (dwell_q >= tmo_lim_s)) begin
            state_d = S_IDLE;
            tmo_d   = 1'b1;
          end else begin
            state_d = S_ON;
          end
        end
        S_OFF: begin
          if (en) begin
            state_d = S_WAIT;
          end else begin
            state_d = S_OFF;
          end
        end
        S_WAIT: begin
          if (dwell_q >= cfg_wait_len) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            if (trip_q != {CW{1'b1}}) begin
              trip_d = trip_q + CW'(1);
            end else begin
              trip_d = trip_q;
            end
          end else begin
            state_d = S_WAIT;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    // Dwell restarts on every state change and only runs in ON and WAIT.
    if (state_d != state_q) begin
      dwell_d = {CW{1'b0}};
    end else if ((state_q == S_ON) || (state_q == S_WAIT)) begin
      if (dwell_q != {CW{1'b1}}) begin
        dwell_d = dwell_q + CW'(1);
      end else begin
        dwell_d = dwell_q;
      end
    end else begin
      dwell_d = {CW{1'b0}};
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      dwell_q <= {CW{1'b0}};
      trip_q  <= {CW{1'b0}};
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
      trip_q  <= trip_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
      busy_q  <= (state_d != S_IDLE);
    end
  end

  assign state         = state_q;
  assign busy          = busy_q;
  assign done_pulse    = done_q;
  assign timeout_pulse = tmo_q;
  assign trip_cnt      = trip_q;

endmodule

// File: tb/tb_fsm_seq_ctrl.sv
// Directed self-checking bench for fsm_seq_ctrl; a second instance with CW=2
// covers trip counter saturation.
module tb_fsm_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data;
  logic       en;
  logic       abort;
  logic [7:0] cfg_idle_pat;
  logic [7:0] cfg_off_pat;
  logic [7:0] cfg_mask;
  logic [7:0] cfg_wait_len;
  logic [7:0] cfg_timeout;
  logic [2:0] state;
  logic       busy;
  logic       done_pulse;
  logic       timeout_pulse;
  logic [7:0] trip_cnt;

  logic [1:0] cfg_wait_len2;
  logic [1:0] cfg_timeout2;
  logic [2:0] state2;
  logic       busy2;
  logic       done2;
  logic       tmo2;
  logic [1:0] trip2;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fsm_seq_ctrl #(.DW(8), .CW(8)) u_dut (
    .clk(clk), .rst(rst), .data(data), .en(en), .abort(abort),
    .cfg_idle_pat(cfg_idle_pat), .cfg_off_pat(cfg_off_pat), .cfg_mask(cfg_mask),
    .cfg_wait_len(cfg_wait_len), .cfg_timeout(cfg_timeout),
    .state(state), .busy(busy), .done_pulse(done_pulse),
    .timeout_pulse(timeout_pulse), .trip_cnt(trip_cnt)
  );

  fsm_seq_ctrl #(.DW(8), .CW(2)) u_dut2 (
    .clk(clk), .rst(rst), .data(data), .en(en), .abort(abort),
    .cfg_idle_pat(cfg_idle_pat), .cfg_off_pat(cfg_off_pat), .cfg_mask(cfg_mask),
    .cfg_wait_len(cfg_wait_len2), .cfg_timeout(cfg_timeout2),
    .state(state2), .busy(busy2), .done_pulse(done2),
    .timeout_pulse(tmo2), .trip_cnt(trip2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full legacy-pattern trip: ON, OFF, WAIT (one cycle with wait_len 0), IDLE.
  task automatic run_trip();
    data = 8'h00; en = 1'b1; tick();
    en = 1'b0; data = 8'hF0; tick();
    data = 8'h0F; en = 1'b1; tick();
    en = 1'b0; tick();
  endtask

  initial begin
    rst = 1'b1; data = 8'h0F; en = 1'b0; abort = 1'b0;
    cfg_idle_pat = 8'h0F; cfg_off_pat = 8'hF0; cfg_mask = 8'hFF;
    cfg_wait_len = 8'd0; cfg_timeout = 8'd0;
    cfg_wait_len2 = 2'd0; cfg_timeout2 = 2'd0;
    tick(); tick();
    chk("rst_state", 8'(state), 8'h00);
    chk("rst_busy", 8'(busy), 8'h00);
    chk("rst_done", 8'(done_pulse), 8'h00);
    chk("rst_tmo", 8'(timeout_pulse), 8'h00);
    chk("rst_trip", trip_cnt, 8'h00);
    rst = 1'b0;
    tick();
    chk("idle_hold", 8'(state), 8'h00);

    // Legacy mode
    data = 8'h00; en = 1'b1; tick();
    chk("leg_on", 8'(state), 8'h01);
    chk("leg_busy", 8'(busy), 8'h01);
    en = 1'b0; data = 8'hF0; tick();
    chk("leg_off", 8'(state), 8'h02);
    data = 8'h0F; tick();
    chk("leg_off_hold", 8'(state), 8'h02);
    en = 1'b1; tick();
    chk("leg_wait", 8'(state), 8'h04);
    chk("leg_wait_nodone", 8'(done_pulse), 8'h00);
    en = 1'b0; tick();
    chk("leg_idle", 8'(state), 8'h00);
    chk("leg_done", 8'(done_pulse), 8'h01);
    chk("leg_trip", trip_cnt, 8'h01);
    tick();
    chk("leg_done_clr", 8'(done_pulse), 8'h00);
    chk("leg_busy_clr", 8'(busy), 8'h00);

    // Masked match and WAIT dwell of 4 cycles
    cfg_mask = 8'hF0; cfg_off_pat = 8'hA0; cfg_wait_len = 8'd3;
    data = 8'h3C; en = 1'b1; tick();
    chk("msk_on", 8'(state), 8'h01);
    en = 1'b0; data = 8'h55; tick();
    chk("msk_on_hold", 8'(state), 8'h01);
    data = 8'hA7; tick();
    chk("msk_off", 8'(state), 8'h02);
    data = 8'h0F; en = 1'b1; tick();
    chk("msk_wait0", 8'(state), 8'h04);
    en = 1'b0;
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("msk_wait_n", 8'(state), 8'h04);
      chk("msk_wait_nodone", 8'(done_pulse), 8'h00);
    end
    tick();
    chk("msk_idle", 8'(state), 8'h00);
    chk("msk_done", 8'(done_pulse), 8'h01);
    chk("msk_trip", trip_cnt, 8'h02);
    cfg_mask = 8'hFF; cfg_off_pat = 8'hF0; cfg_wait_len = 8'd0;
    tick();

    // Timeout: ON lasts exactly 5 cycles
    cfg_timeout = 8'd5;
    data = 8'h00; en = 1'b1; tick();
    chk("tmo_on0", 8'(state), 8'h01);
    en = 1'b0;
    for (int i = 1; i < 5; i++) begin
      tick();
      chk("tmo_on_n", 8'(state), 8'h01);
      chk("tmo_no_pulse", 8'(timeout_pulse), 8'h00);
    end
    tick();
    chk("tmo_idle", 8'(state), 8'h00);
    chk("tmo_pulse", 8'(timeout_pulse), 8'h01);
    chk("tmo_nodone", 8'(done_pulse), 8'h00);
    chk("tmo_trip", trip_cnt, 8'h02);
    tick();
    chk("tmo_pulse_clr", 8'(timeout_pulse), 8'h00);

    // off_hit coincides with timeout expiry
    cfg_timeout = 8'd2;
    data = 8'h00; en = 1'b1; tick();
    en = 1'b0; tick();
    chk("sim_on2", 8'(state), 8'h01);
    data = 8'hF0; tick();
    chk("sim_off", 8'(state), 8'h02);
    chk("sim_no_tmo", 8'(timeout_pulse), 8'h00);
    data = 8'h0F; en = 1'b1; tick();
    en = 1'b0; tick();
    chk("sim_trip", trip_cnt, 8'h03);
    cfg_timeout = 8'd0;

    // Abort in WAIT, then abort in IDLE
    cfg_wait_len = 8'd10;
    data = 8'h00; en = 1'b1; tick();
    en = 1'b0; data = 8'hF0; tick();
    data = 8'h0F; en = 1'b1; tick();
    en = 1'b0; tick();
    chk("abt_wait", 8'(state), 8'h04);
    abort = 1'b1; tick();
    chk("abt_idle", 8'(state), 8'h00);
    chk("abt_nodone", 8'(done_pulse), 8'h00);
    chk("abt_trip", trip_cnt, 8'h03);
    data = 8'h00; en = 1'b1; tick();
    chk("abt_idle_hold", 8'(state), 8'h00);
    abort = 1'b0; en = 1'b0;

    // Reset in ON
    en = 1'b1; tick();
    chk("rst_on_pre", 8'(state), 8'h01);
    en = 1'b0; rst = 1'b1; tick();
    chk("rst_on_state", 8'(state), 8'h00);
    chk("rst_on_trip", trip_cnt, 8'h00);
    chk("rst_on_tmo", 8'(timeout_pulse), 8'h00);
    rst = 1'b0;

    // Live lowering of wait length while dwell=4
    cfg_wait_len = 8'd7;
    data = 8'h00; en = 1'b1; tick();
    en = 1'b0; data = 8'hF0; tick();
    data = 8'h0F; en = 1'b1; tick();
    en = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("live_wait", 8'(state), 8'h04);
    cfg_wait_len = 8'd1; tick();
    chk("live_idle", 8'(state), 8'h00);
    chk("live_done", 8'(done_pulse), 8'h01);
    chk("live_trip", trip_cnt, 8'h01);
    cfg_wait_len = 8'd0;

    // Trip counter saturation on the CW=2 instance
    rst = 1'b1; tick(); rst = 1'b0;
    chk("sat_rst", 8'(trip2), 8'h00);
    for (int i = 1; i <= 5; i++) begin
      run_trip();
      chk("sat_trip2", 8'(trip2), (i > 3) ? 8'd3 : 8'(i));
      chk("sat_trip8", trip_cnt, 8'(i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fsm_seq_ctrl.md
Name: fsm_seq_ctrl

Overview:
- Parametrised successor of the four-state IDLE/ON/OFF/WAIT data-pattern controller.
- Adds:
  - configurable data width;
  - masked, runtime-programmable match patterns;
  - a programmable WAIT dwell;
  - an ON-state timeout;
  - synchronous abort;
  - completion/timeout pulses and a saturating trip counter.
- Sits between a byte/word stream source and downstream sequencing logic, and exposes the current state for status readback.

Parameters:
- DW, 8, width of data and pattern/mask inputs.
- CW, 8, width of dwell/timeout config, internal dwell counter and trip counter.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- data  input  DW  monitored data word.
- en  input  1  qualifier for IDLE->ON and OFF->WAIT.
- abort  input  1  force return to IDLE.
- cfg_idle_pat  input  DW  IDLE hold pattern; IDLE leaves when data mismatches it.
- cfg_off_pat  input  DW  ON->OFF trigger pattern.
- cfg_mask  input  DW  compare mask; 1 = bit participates.
- cfg_wait_len  input  CW  extra WAIT cycles; WAIT lasts cfg_wait_len+1 cycles.
- cfg_timeout  input  CW  ON timeout in cycles; 0 = disabled.
- state  output  3  current state: IDLE=000, ON=001, OFF=010, WAIT=100.
- busy  output  1  high when state != IDLE.
- done_pulse  output  1  one-cycle pulse on the normal WAIT->IDLE exit.
- timeout_pulse  output  1  one-cycle pulse on the ON->IDLE timeout exit.
- trip_cnt  output  CW  count of completed trips; saturates at all-ones.

Behaviour:
- Reset (rst=1 at clk edge):
  - state=IDLE, dwell counter=0, trip_cnt=0, done_pulse=0, timeout_pulse=0.
  - Reset overrides all other inputs, including mid-trip.
- All outputs are registered. State changes are visible one cycle after the qualifying input.
- Masked compare, combinational on current inputs:
  - idle_hit = ((data ^ cfg_idle_pat) & cfg_mask) == 0.
  - off_hit = ((data ^ cfg_off_pat) & cfg_mask) == 0.
  - cfg_mask=0 makes both hits true.
- Dwell counter (width CW):
  - Cleared on every state change.
  - Otherwise increments each cycle in ON and WAIT; saturates at all-ones.
  - Held at 0 in IDLE and OFF.
- Transition priority, highest first: rst, abort, per-state rules.
- abort=1:
  - Next state is IDLE from any state.
  - No done_pulse, no timeout_pulse, trip_cnt unchanged.
  - abort in IDLE has no effect.
- IDLE:
  - Goes to ON if en && !idle_hit; otherwise stays IDLE.
- ON:
  - If off_hit, goes to OFF. This has priority over timeout in the same cycle.
  - Else if cfg_timeout!=0 and dwell >= cfg_timeout-1, goes to IDLE and timeout_pulse=1 next cycle.
  - Otherwise stays ON.
  - So ON lasts at most cfg_timeout cycles.
- OFF:
  - Goes to WAIT if en; otherwise stays OFF. No timeout.
- WAIT:
  - If dwell >= cfg_wait_len, goes to IDLE, done_pulse=1, and trip_cnt increments (saturating).
  - Otherwise stays WAIT.
- cfg_* inputs are sampled live every cycle, with no shadowing.
  - Lowering cfg_wait_len or cfg_timeout below the current dwell forces exit on the next edge (>= compare).
- done_pulse and timeout_pulse:
  - Never both high in the same cycle.
  - Each is high for exactly one cycle per event.
- With defaults cfg_mask=FF, cfg_idle_pat=0F, cfg_off_pat=F0, cfg_wait_len=0, cfg_timeout=0, the transition behaviour matches the legacy controller.

Test Plan:
- Legacy mode:
  - Stimulus: defaults above; data=0x00, en=1 one cycle; then data=0xF0; then en=1.
  - Required: state 000->001->010->100->000 on successive qualifying edges; WAIT lasts 1 cycle; done_pulse=1 once; trip_cnt=1.
- Masked match and WAIT dwell:
  - Stimulus: cfg_mask=0xF0, cfg_off_pat=0xA0, cfg_wait_len=3; in ON, apply data=0xA7.
  - Required: ON->OFF on data=0xA7. After en, WAIT lasts exactly 4 cycles, then IDLE with done_pulse.
- Timeout:
  - Stimulus: cfg_timeout=5; enter ON; data never matches off pattern.
  - Required: exactly 5 cycles in ON, then IDLE with timeout_pulse=1 for one cycle; trip_cnt unchanged.
- Simultaneous off_hit and timeout:
  - Stimulus: cfg_timeout=2; off_hit asserted on the 2nd ON cycle.
  - Required: goes to OFF; no timeout_pulse.
- Abort and reset mid-trip:
  - Stimulus: abort=1 in WAIT with cfg_wait_len=10.
  - Required: IDLE next cycle; no done_pulse; trip_cnt held.
  - Stimulus: rst=1 in ON.
  - Required: IDLE, trip_cnt=0, pulses low on that edge.
- Saturation and live config:
  - Stimulus: CW=2; run 5 complete trips.
  - Required: trip_cnt sticks at 3.
  - Stimulus: lower cfg_wait_len from 7 to 1 while dwell=4.
  - Required: WAIT->IDLE on the next edge.
